// File: rtl/poly1305_msg_loader.sv
// Message loader for the poly1305 core: latches the key, packs a byte stream
// little-endian into padded 128-bit blocks, issues them, and returns the tag.
module poly1305_msg_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         key_valid,
   input  logic [255:0] key,
   output logic         key_ready,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic [127:0] core_r,
   output logic [127:0] core_s,
   output logic [127:0] core_m,
   output logic         core_fb,
   output logic         core_ld,
   output logic         core_first,
   input  logic         core_rdy,
   input  logic [127:0] core_p,
   output logic [127:0] tag,
   output logic         tag_valid,
   input  logic         tag_ready,
   output logic         err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ISSUE,
      S_WAIT,
      S_TAG
   } state_e;

   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            first_q, first_d;
   logic            last_q, last_d;
   logic            fb_q, fb_d;
   logic [127:0]    m_q, m_d;
   logic [127:0]    r_q, r_d;
   logic [127:0]    s_q, s_d;
   logic [127:0]    tag_q, tag_d;
   logic            err_q, err_d;
   logic [WD_W-1:0] wd_q, wd_d;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values computed before this edge.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         first_q <= 1'b1;
         last_q  <= 1'b0;
         fb_q    <= 1'b0;
         m_q     <= '0;
         r_q     <= '0;
         s_q     <= '0;
         tag_q   <= '0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         last_q  <= last_d;
         fb_q    <= fb_d;
         m_q     <= m_d;
         r_q     <= r_d;
         s_q     <= s_d;
         tag_q   <= tag_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      // NOTE: every next-state value defaults to its current value first, so
      // no path through the case statement can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      last_d  = last_q;
      fb_d    = fb_q;
      m_d     = m_q;
      r_d     = r_q;
      s_d     = s_q;
      tag_d   = tag_q;
      err_d   = err_q;
      wd_d    = wd_q;

      unique case (state_q)
         S_IDLE: begin
            if (key_valid) begin
               r_d     = key[127:0];
               s_d     = key[255:128];
               m_d     = '0;
               cnt_d   = '0;
               fb_d    = 1'b0;
               first_d = 1'b1;
               last_d  = 1'b0;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            if (in_valid) begin
               m_d[{cnt_q, 3'b000} +: 8] = in_data;
               cnt_d = cnt_q + 4'd1;
               if (in_last) begin
                  fb_d = (cnt_q == 4'd15);
                  // Partial final block: a single 0x01 pad byte right after the data.
                  if (cnt_q != 4'd15) m_d[{cnt_q + 4'd1, 3'b000} +: 8] = 8'h01;
                  last_d  = 1'b1;
                  state_d = S_ISSUE;
               end else if (cnt_q == 4'd15) begin
                  fb_d    = 1'b1;
                  last_d  = 1'b0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (core_rdy) begin
               if (last_q) begin
                  tag_d   = core_p;
                  state_d = S_TAG;
               end else begin
                  m_d     = '0;
                  cnt_d   = '0;
                  fb_d    = 1'b0;
                  first_d = 1'b0;
                  state_d = S_FILL;
               end
            end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_MAX)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_TAG: begin
            if (tag_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      key_ready  = (state_q == S_IDLE);
      in_ready   = (state_q == S_FILL);
      core_ld    = (state_q == S_ISSUE);
      core_first = first_q & ((state_q == S_ISSUE) | (state_q == S_WAIT));
      tag_valid  = (state_q == S_TAG);
      core_r     = r_q;
      core_s     = s_q;
      core_m     = m_q;
      core_fb    = fb_q;
      tag        = tag_q;
      err        = err_q;
   end

endmodule

// File: tb/tb_poly1305_msg_loader.sv
// Self-checking bench for poly1305_msg_loader: directed scenarios plus random
// messages compared against a block-level packing model.
module tb_poly1305_msg_loader;

   typedef logic [7:0] byte_q_t[$];

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic         key_valid = 1'b0;
   logic [255:0] key = '0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_last = 1'b0;
   logic         core_rdy = 1'b0;
   logic [127:0] core_p = '0;
   logic         tag_ready = 1'b0;

   logic         key_ready, in_ready, core_fb, core_ld, core_first, tag_valid, err;
   logic [127:0] core_r, core_s, core_m, tag;
   logic         w_key_ready, w_in_ready, w_core_fb, w_core_ld, w_core_first, w_tag_valid, w_err;
   logic [127:0] w_core_r, w_core_s, w_core_m, w_tag;

   int n_checks = 0;
   int n_pass = 0;
   int ld_cnt = 0;

   always #5 clk = ~clk;

   poly1305_msg_loader dut (
      .clk(clk), .rst_ni(rst_ni),
      .key_valid(key_valid), .key(key), .key_ready(key_ready),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .core_r(core_r), .core_s(core_s), .core_m(core_m), .core_fb(core_fb),
      .core_ld(core_ld), .core_first(core_first), .core_rdy(core_rdy), .core_p(core_p),
      .tag(tag), .tag_valid(tag_valid), .tag_ready(tag_ready), .err(err)
   );

   poly1305_msg_loader #(.TIMEOUT_CYCLES(8)) dut_wd (
      .clk(clk), .rst_ni(rst_ni),
      .key_valid(key_valid), .key(key), .key_ready(w_key_ready),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(w_in_ready),
      .core_r(w_core_r), .core_s(w_core_s), .core_m(w_core_m), .core_fb(w_core_fb),
      .core_ld(w_core_ld), .core_first(w_core_first), .core_rdy(core_rdy), .core_p(core_p),
      .tag(w_tag), .tag_valid(w_tag_valid), .tag_ready(tag_ready), .err(w_err)
   );

   always @(negedge clk) if (core_ld === 1'b1) ld_cnt++;

   task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   task automatic reset_dut();
      rst_ni    = 1'b0;
      key_valid = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      core_rdy  = 1'b0;
      tag_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
   endtask

   task automatic load_key(input logic [255:0] k);
      int budget = 0;
      while (key_ready !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check("key_ready", key_ready, 1'b1);
      key       = k;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   // Expected block b of a message: bytes little-endian, 0x01 pad after a short tail.
   function automatic logic [128:0] model_block(input byte_q_t msg, input int b);
      logic [127:0] m = '0;
      int start = 16 * b;
      int cnt = (msg.size() - start > 16) ? 16 : msg.size() - start;
      for (int j = 0; j < cnt; j++) m[8*j +: 8] = msg[start + j];
      if (cnt < 16) m[8*cnt +: 8] = 8'h01;
      return {(cnt == 16) ? 1'b1 : 1'b0, m};
   endfunction

   // Sends bytes of block b; leaves the bench at the negedge of the ISSUE cycle.
   task automatic send_block(input byte_q_t msg, input int b);
      int start = 16 * b;
      int cnt = (msg.size() - start > 16) ? 16 : msg.size() - start;
      bit ok = 1'b1;
      for (int j = 0; j < cnt; j++) begin
         in_valid = 1'b1;
         in_data  = msg[start + j];
         in_last  = (start + j == msg.size() - 1);
         ok &= (in_ready === 1'b1) && (core_ld === 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("fill_in_ready", ok, 1'b1);
   endtask

   task automatic run_msg(input logic [255:0] k, input byte_q_t msg, input int rdy_dly,
                          input int tag_hold, input logic [127:0] p);
      int nblk = (msg.size() + 15) / 16;
      int ld0;
      logic [128:0] e;
      bit ok;
      load_key(k);
      ld0 = ld_cnt;
      for (int b = 0; b < nblk; b++) begin
         e = model_block(msg, b);
         send_block(msg, b);
         check("issue_ld", core_ld, 1'b1);
         check("issue_m", core_m, e[127:0]);
         check("issue_fb", core_fb, e[128]);
         check("issue_first", core_first, (b == 0));
         if (b == 0) check("key_rs", {core_s, core_r}, k);
         ok = 1'b1;
         repeat (rdy_dly + 1) begin
            @(negedge clk);
            ok &= (core_m === e[127:0]) && (core_fb === e[128]) && (core_first === (b == 0))
                  && (core_ld === 1'b0) && (in_ready === 1'b0) && (tag_valid === 1'b0);
         end
         check("wait_stable", ok, 1'b1);
         core_rdy = 1'b1;
         core_p   = (b == nblk - 1) ? p : {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         core_rdy = 1'b0;
         core_p   = {$urandom, $urandom, $urandom, $urandom};
         if (b < nblk - 1) check("refill_in_ready", in_ready, 1'b1);
      end
      check("tag_valid", tag_valid, 1'b1);
      check("tag_value", tag, p);
      ok = 1'b1;
      repeat (tag_hold) begin
         @(negedge clk);
         ok &= (tag_valid === 1'b1) && (tag === p) && (key_ready === 1'b0) && (core_ld === 1'b0);
      end
      check("tag_hold", ok, 1'b1);
      tag_ready = 1'b1;
      @(negedge clk);
      tag_ready = 1'b0;
      check("tag_dropped", tag_valid, 1'b0);
      check("tag_kept", tag, p);
      check("back_idle", key_ready, 1'b1);
      check("ld_pulses", ld_cnt - ld0, nblk);
      check("no_err", err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: observed time limit expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      byte_q_t msg;
      logic [255:0] k;

      // Reset state
      #2;
      check("rst_rs", {core_s, core_r}, '0);
      check("rst_mt", {tag, core_m}, '0);
      check("rst_ctl", {core_fb, core_ld, core_first, tag_valid, in_ready, err}, '0);
      reset_dut();
      check("idle_key_ready", key_ready, 1'b1);

      // Full single block 00..0F
      msg = {};
      for (int i = 0; i < 16; i++) msg.push_back(8'(i));
      run_msg({128'h0123456789abcdef_fedcba9876543210, {16{8'h01}}}, msg, 2, 1,
              128'hdeadbeef_00112233_44556677_8899aabb);
      check("full_block_m", core_m, 128'h0f0e0d0c0b0a09080706050403020100);

      // Partial block AA BB CC
      msg = {};
      msg.push_back(8'haa); msg.push_back(8'hbb); msg.push_back(8'hcc);
      run_msg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              msg, 0, 0, 128'h1);
      check("partial_m", core_m, 128'h01ccbbaa);

      // Two blocks, 20 bytes
      msg = {};
      for (int i = 0; i < 20; i++) msg.push_back(8'(8'h30 + i));
      run_msg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              msg, 1, 0, 128'h2);
      check("two_block_m", core_m, 128'h01_43424140);

      // Stall: rdy 50 cycles late, tag held 10 cycles
      msg = {};
      for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
      run_msg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              msg, 50, 10, 128'h5a5a_a5a5);

      // Random messages
      for (int n = 0; n < 6; n++) begin
         msg = {};
         for (int i = 0; i < int'($urandom_range(1, 40)); i++) msg.push_back(8'($urandom));
         k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run_msg(k, msg, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom});
      end

      // Watchdog on the TIMEOUT_CYCLES=8 instance
      reset_dut();
      msg = {};
      msg.push_back(8'h10); msg.push_back(8'h20); msg.push_back(8'h30);
      load_key({8{32'hc0ffee00}});
      send_block(msg, 0);
      check("wd_issue", w_core_ld, 1'b1);
      repeat (8) @(negedge clk);
      check("wd_not_yet", w_err, 1'b0);
      @(negedge clk);
      check("wd_err", w_err, 1'b1);
      check("wd_idle", w_key_ready, 1'b1);
      check("main_no_err", err, 1'b0);
      repeat (3) @(negedge clk);
      check("wd_sticky", w_err, 1'b1);

      // Reset mid-block after 7 bytes, then a clean 2-byte message
      reset_dut();
      load_key({8{32'h12345678}});
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom_range(2, 255));
         in_last  = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      check("midrst_rs", {core_s, core_r}, '0);
      check("midrst_mt", {tag, core_m}, '0);
      check("midrst_ctl", {core_fb, core_ld, core_first, tag_valid, in_ready, err, w_err}, '0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      msg = {};
      msg.push_back(8'h11); msg.push_back(8'h22);
      run_msg({8{32'h87654321}}, msg, 0, 0, 128'h77);
      check("post_rst_m", core_m, 128'h012211);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/poly1305_msg_loader.md
Name: poly1305_msg_loader

Overview:
- Upstream sequencer for the poly1305 core.
- Latches the 256-bit one-time key and accepts the message as a byte stream.
- Packs bytes little-endian into 128-bit blocks, pads the final partial block, and drives the core's m/fb/ld/first inputs one block at a time, waiting on the core's rdy pulse.
- Captures the core's p output after the last block and presents it as the tag with a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles in WAIT for core_rdy before err is raised. 0 disables the watchdog.

Ports:
- clk  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- key_valid  input  1  key present on key.
- key  input  256  one-time key; r = key[127:0], s = key[255:128].
- key_ready  output  1  key accepted when key_valid & key_ready.
- in_valid  input  1  message byte valid.
- in_data  input  8  message byte.
- in_last  input  1  byte is the last of the message.
- in_ready  output  1  byte accepted when in_valid & in_ready.
- core_r  output  128  to core r; registered key[127:0].
- core_s  output  128  to core s; registered key[255:128].
- core_m  output  128  to core m.
- core_fb  output  1  to core fb; 1 = full 16-byte block.
- core_ld  output  1  to core ld; one-cycle start pulse.
- core_first  output  1  to core first; block is first of the message.
- core_rdy  input  1  core block-done pulse.
- core_p  input  128  core tag output.
- tag  output  128  final tag.
- tag_valid  output  1  tag present.
- tag_ready  input  1  tag consumed.
- err  output  1  sticky watchdog timeout flag.

Behaviour:
- Reset: asynchronous, active-low. All registers clear: state=IDLE, byte count=0, first_flag=1. All outputs are 0, including core_r, core_s, core_m, tag and err.
- State IDLE:
  - key_ready=1.
  - On key_valid, latch key into core_r/core_s, clear the block buffer, set first_flag=1, and go to FILL.
- State FILL:
  - in_ready=1.
  - An accepted byte with count n (0..15) is written to core_m[8n+7:8n], then count increments.
  - Accepted byte with count=15 and in_last=0: core_fb=1, go to ISSUE, last_flag=0.
  - Accepted byte with in_last=1:
    - If n=15 (full final block): core_fb=1.
    - Otherwise: core_fb=0, byte n+1 is set to 8'h01 and bytes above it stay 0.
    - Set last_flag=1 and go to ISSUE.
- State ISSUE:
  - Lasts one cycle. core_ld=1 and core_first=first_flag.
  - Next state is WAIT.
- State WAIT:
  - core_m, core_fb and core_first stay stable; in_ready=0.
  - On core_rdy with last_flag=0: clear the buffer and count, set first_flag=0, go to FILL.
  - On core_rdy with last_flag=1: capture tag<=core_p and go to TAG.
  - The watchdog counts cycles in WAIT. Reaching TIMEOUT_CYCLES sets err=1 and returns to IDLE; the message is abandoned.
  - A core_rdy pulse in any other state is ignored.
- State TAG:
  - tag_valid=1 and tag is held.
  - On tag_ready: go to IDLE. tag_valid drops the next cycle; tag keeps its value.
- Buffer clearing: cleared on entry to FILL from IDLE and from WAIT. A partial block never carries stale bytes.
- Latency:
  - core_ld asserts the cycle after the 16th or last byte is accepted.
  - A new FILL begins the cycle after core_rdy.
  - tag_valid asserts the cycle after the final core_rdy.
- Zero-length messages are unsupported. Each message carries at least one byte with in_last.
- err clears only on reset.
- Reset mid-operation: everything returns to reset values immediately. The core is not informed; its next block uses first=1.

Test Plan:
- Full single block: key r=0x...01 pattern, 16 bytes 0x00..0x0F with in_last on the 16th -> one core_ld pulse, core_m=128'h0F0E..0100, core_fb=1, core_first=1; after core_rdy, tag=core_p, tag_valid=1.
- Partial block: 3 bytes AA BB CC, last on CC -> core_m=128'h01CCBBAA, core_fb=0, core_first=1.
- Two blocks: 20 bytes -> first ld with fb=1, first=1; second ld with core_m bytes 0..3 = data, byte 4 = 0x01, fb=0, first=0. Exactly two core_ld pulses; in_ready=0 while in WAIT.
- Backpressure/stall: core_rdy delayed 50 cycles -> core_m, core_fb, core_first stable throughout; in_ready=0; no extra ld; tag_ready held low 10 cycles -> tag_valid held, tag unchanged.
- Watchdog: TIMEOUT_CYCLES=8, core_rdy never arrives -> err=1 after 8 WAIT cycles, state IDLE, key_ready=1.
- Reset mid-block: assert rst_ni=0 after 7 bytes -> all outputs 0 asynchronously. Next message of 2 bytes 11 22 gives core_m=128'h012211 with no stale bytes.
